instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program ROM.
- Owns the program counter and drives the ROM address. Captures the ROM instruction words and assembles 16-bit or 32-bit AVR instructions.
- Presents each instruction to decode over a valid/ready handshake and accepts branch/jump redirects from execute.
- The ROM registers its output on negedge, so rom_data sampled at a posedge always equals mem[rom_addr] as driven during the preceding cycle.

Parameters:
- DATA_WIDTH, 16, instruction word width.
- ADDR_WIDTH, 8, word-address (PC) width; must match the ROM.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_WIDTH  word address to ROM; equals internal pc register.
- rom_data  in  DATA_WIDTH  ROM instruction word for the previous cycle's rom_addr.
- pc_load  in  1  redirect request from execute.
- pc_target  in  ADDR_WIDTH  redirect destination.
- instr_valid  out  1  output buffer holds a complete instruction.
- instr_ready  in  1  decode accepts the instruction this cycle.
- instr_word0  out  DATA_WIDTH  first (opcode) word.
- instr_word1  out  DATA_WIDTH  second word; 0 for 16-bit instructions.
- instr_is32  out  1  instruction is two words.
- instr_pc  out  ADDR_WIDTH  address of instr_word0.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - pc = RESET_VECTOR.
  - state = S_W0.
  - instr_valid = 0.
  - instr_word0 = 0, instr_word1 = 0, instr_is32 = 0, instr_pc = 0.
- Reset asserted mid-instruction discards everything. The first fetch after reset release is from RESET_VECTOR.
- Definition: buf_free = !instr_valid || instr_ready.
- Two-word detect on rom_data:
  - LDS/STS when (w & 16'hFC0F) == 16'h9000.
  - JMP/CALL when (w & 16'hFE0C) == 16'h940C.
  - All other words are single-word.
- State S_W0, on posedge with buf_free:
  - Single-word: load the output buffer (word0 = rom_data, word1 = 0, is32 = 0, instr_pc = pc); instr_valid = 1; pc = pc + 1; stay in S_W0.
  - Two-word: hold the word in an internal latch along with its pc; instr_valid = 0 (the buffer is drained if instr_ready); pc = pc + 1; go to S_W1.
- State S_W0 with !buf_free: pc, state and buffer are all held.
- State S_W1, on posedge: buf_free is guaranteed because the buffer was emptied on entry. Load the output buffer (word0 = latch, word1 = rom_data, is32 = 1, instr_pc = latched pc); instr_valid = 1; pc = pc + 1; go to S_W0.
- Throughput with instr_ready held high:
  - One 16-bit instruction per cycle.
  - A 32-bit instruction occupies 2 cycles.
  - Latency from reset release to first instr_valid is 1 cycle.
- Handshake rules:
  - A transfer occurs on a posedge with instr_valid && instr_ready.
  - While instr_valid && !instr_ready, all outputs are held stable.
- Redirect (pc_load = 1) has priority over everything except reset:
  - pc = pc_target, state = S_W0, instr_valid = 0, partial latch discarded.
  - This applies even if instr_ready is asserted in the same cycle; the pending instruction is still counted as consumed by decode.
  - The first instruction from the target appears 1 cycle later.
  - pc_load in consecutive cycles: the last target wins.
- PC arithmetic is modulo 2^ADDR_WIDTH:
  - pc at all-ones wraps to 0.
  - A two-word instruction at address 2^ADDR_WIDTH-1 takes its second word from address 0.

Optional Feature:
- Macro: IFETCH_BREAK_HALT_EN.
- When defined:
  - A word 16'h9598 (BREAK) fetched in S_W0 is delivered normally as a 16-bit instruction.
  - Fetch then enters S_HALT: pc stays at BREAK+1 and no further instructions are issued.
  - S_HALT exits only on pc_load or reset.
  - Adds output halted (1 bit, reset 0), high while in S_HALT.
- When undefined: BREAK is an ordinary 16-bit instruction, no S_HALT state exists, and there is no halted port.

Test Plan:
- Reset + straight-line fetch: ROM {0:E803, 1:BB09, 2:E009}, ready=1 -> after reset release instr_pc 0,1,2 on consecutive cycles; word0 = E803, BB09, E009; is32 = 0; rom_addr = 0,1,2,3.
- Two-word instruction: ROM {0:9100, 1:0060, 2:0000}, ready=1 -> one valid cycle with word0 = 9100, word1 = 0060, is32 = 1, instr_pc = 0; next instruction is instr_pc = 2.
- Backpressure: ready=0 for 3 cycles after first valid -> outputs frozen at instr_pc 0 and rom_addr stays 1; ready=1 -> instr_pc 1 next cycle, nothing lost or duplicated.
- Redirect mid-32-bit: pc_load = 1, pc_target = 8'h20 while in S_W1 of a JMP -> instr_valid = 0 next cycle, partial JMP never emitted, then instr_pc = 20.
- Wrap: pc_target = 8'hFF, ROM[FF] = 940C, ROM[0] = 0004 -> word0 = 940C, word1 = 0004, is32 = 1, instr_pc = FF; next fetch from 1.
- IFETCH_BREAK_HALT_EN: ROM {0:9598, 1:E000} -> BREAK delivered at pc 0, then halted = 1 and no valid for 10 cycles; pc_load to 1 -> halted = 0 and E000 delivered.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the program ROM and decode.
// Owns the PC, assembles 16/32-bit AVR instructions and offers them to decode
// over a valid/ready handshake; execute can redirect the PC with pc_load.
// Optional feature macro: IFETCH_BREAK_HALT_EN (BREAK stops fetch until a
// redirect, and adds the 'halted' output).
module instr_fetch #(
   parameter int                    DATA_WIDTH   = 16,
   parameter int                    ADDR_WIDTH   = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_target,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_word0,
   output logic [DATA_WIDTH-1:0] instr_word1,
   output logic                  instr_is32,
`ifdef IFETCH_BREAK_HALT_EN
   output logic                  halted,
`endif
   output logic [ADDR_WIDTH-1:0] instr_pc
);

`ifdef IFETCH_BREAK_HALT_EN
   typedef enum logic [1:0] {S_W0, S_W1, S_HALT} state_t;
   localparam logic [DATA_WIDTH-1:0] BREAK_WORD = DATA_WIDTH'(16'h9598);
`else
   typedef enum logic [1:0] {S_W0, S_W1} state_t;
`endif

   localparam logic [DATA_WIDTH-1:0] LDS_MASK  = DATA_WIDTH'(16'hFC0F);
   localparam logic [DATA_WIDTH-1:0] LDS_MATCH = DATA_WIDTH'(16'h9000);
   localparam logic [DATA_WIDTH-1:0] JMP_MASK  = DATA_WIDTH'(16'hFE0C);
   localparam logic [DATA_WIDTH-1:0] JMP_MATCH = DATA_WIDTH'(16'h940C);

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] pc, pc_n;
   logic [DATA_WIDTH-1:0] latch_word, latch_word_n;
   logic [ADDR_WIDTH-1:0] latch_pc, latch_pc_n;
   logic                  valid_q, valid_n;
   logic [DATA_WIDTH-1:0] word0_q, word0_n;
   logic [DATA_WIDTH-1:0] word1_q, word1_n;
   logic                  is32_q, is32_n;
   logic [ADDR_WIDTH-1:0] ipc_q, ipc_n;
   logic                  buf_free;
   logic                  two_word;

   assign buf_free    = !valid_q || instr_ready;
   assign two_word    = ((rom_data & LDS_MASK) == LDS_MATCH) ||
                        ((rom_data & JMP_MASK) == JMP_MATCH);
   assign rom_addr    = pc;
   assign instr_valid = valid_q;
   assign instr_word0 = word0_q;
   assign instr_word1 = word1_q;
   assign instr_is32  = is32_q;
   assign instr_pc    = ipc_q;
`ifdef IFETCH_BREAK_HALT_EN
   assign halted      = (state == S_HALT);
`endif

   // Next-state logic: redirect beats everything; otherwise fetch only when the output buffer can take a word.
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      latch_word_n = latch_word;
      latch_pc_n   = latch_pc;
      valid_n      = valid_q;
      word0_n      = word0_q;
      word1_n      = word1_q;
      is32_n       = is32_q;
      ipc_n        = ipc_q;
      if (pc_load) begin
         pc_n    = pc_target;
         state_n = S_W0;
         valid_n = 1'b0;
      end else begin
         case (state)
            S_W0: begin
               if (buf_free) begin
                  pc_n = pc + 1'b1;
                  if (two_word) begin
                     latch_word_n = rom_data;
                     latch_pc_n   = pc;
                     valid_n      = 1'b0;
                     state_n      = S_W1;
                  end else begin
                     word0_n = rom_data;
                     word1_n = '0;
                     is32_n  = 1'b0;
                     ipc_n   = pc;
                     valid_n = 1'b1;
`ifdef IFETCH_BREAK_HALT_EN
                     if (rom_data == BREAK_WORD) begin
                        state_n = S_HALT;
                     end
`endif
                  end
               end
            end
            S_W1: begin
               word0_n = latch_word;
               word1_n = rom_data;
               is32_n  = 1'b1;
               ipc_n   = latch_pc;
               valid_n = 1'b1;
               pc_n    = pc + 1'b1;
               state_n = S_W0;
            end
`ifdef IFETCH_BREAK_HALT_EN
            S_HALT: begin
               if (instr_ready) begin
                  valid_n = 1'b0;
               end
            end
`endif
            default: begin
               state_n = S_W0;
            end
         endcase
      end
   end

   // State register: synchronous reset discards any partial instruction and restarts at the reset vector.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_W0;
         pc         <= RESET_VECTOR;
         latch_word <= '0;
         latch_pc   <= '0;
         valid_q    <= 1'b0;
         word0_q    <= '0;
         word1_q    <= '0;
         is32_q     <= 1'b0;
         ipc_q      <= '0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         latch_word <= latch_word_n;
         latch_pc   <= latch_pc_n;
         valid_q    <= valid_n;
         word0_q    <= word0_n;
         word1_q    <= word1_n;
         is32_q     <= is32_n;
         ipc_q      <= ipc_n;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with an instruction-stream
// model (expected next instruction from ROM contents and the PC) plus literal
// cycle-accurate expectations. Halt checks build only with IFETCH_BREAK_HALT_EN.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        pc_load;
   logic [7:0]  pc_target;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_word0;
   logic [15:0] instr_word1;
   logic        instr_is32;
   logic [7:0]  instr_pc;
`ifdef IFETCH_BREAK_HALT_EN
   logic        halted;
`endif

   logic [15:0] mem [0:255];
   int          checks = 0;
   int          errors = 0;

   logic [7:0]  mpc = 8'h00;
   logic        holdArmed = 1'b0;
   logic [15:0] snapW0, snapW1;
   logic [7:0]  snapPc, snapAddr;
   logic        snapIs32;

   instr_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
      .clk         (clk),
      .reset       (reset),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .pc_load     (pc_load),
      .pc_target   (pc_target),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_word0 (instr_word0),
      .instr_word1 (instr_word1),
      .instr_is32  (instr_is32),
`ifdef IFETCH_BREAK_HALT_EN
      .halted      (halted),
`endif
      .instr_pc    (instr_pc)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // ROM model: output registered on negedge from the current address.
   always @(negedge clk) rom_data <= mem[rom_addr];

   // AVR two-word opcodes: LDS/STS (1001 00xx xxxx 0000) and JMP/CALL (1001 010x xxxx 11xx).
   function automatic logic isTwoWord(input logic [15:0] w);
      return (w[15:10] == 6'b100100 && w[3:0] == 4'b0000) ||
             (w[15:9] == 7'b1001010 && w[3:2] == 2'b11);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then return just after the following posedge.
   task automatic applyStimulus(input logic r, input logic ld, input logic [7:0] tgt, input logic rdy);
      reset       = r;
      pc_load     = ld;
      pc_target   = tgt;
      instr_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
   endtask

   // Stream model: every transfer must be the next instruction in program order from the model PC.
   always @(negedge clk) begin
      if (reset) begin
         mpc       = 8'h00;
         holdArmed = 1'b0;
      end else begin
         if (holdArmed) begin
            checkOutput("hold_valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("hold_word0", {16'd0, instr_word0}, {16'd0, snapW0});
            checkOutput("hold_word1", {16'd0, instr_word1}, {16'd0, snapW1});
            checkOutput("hold_pc", {24'd0, instr_pc}, {24'd0, snapPc});
            checkOutput("hold_is32", {31'd0, instr_is32}, {31'd0, snapIs32});
            checkOutput("hold_addr", {24'd0, rom_addr}, {24'd0, snapAddr});
         end
         holdArmed = 1'b0;
         if (instr_valid && instr_ready) begin
            logic [15:0] w0, w1;
            logic        t;
            w0 = mem[mpc];
            t  = isTwoWord(w0);
            w1 = t ? mem[8'(mpc + 8'd1)] : 16'h0000;
            checkOutput("stream_pc", {24'd0, instr_pc}, {24'd0, mpc});
            checkOutput("stream_word0", {16'd0, instr_word0}, {16'd0, w0});
            checkOutput("stream_word1", {16'd0, instr_word1}, {16'd0, w1});
            checkOutput("stream_is32", {31'd0, instr_is32}, {31'd0, t});
            mpc = t ? 8'(mpc + 8'd2) : 8'(mpc + 8'd1);
         end else if (instr_valid && !pc_load) begin
            snapW0    = instr_word0;
            snapW1    = instr_word1;
            snapPc    = instr_pc;
            snapIs32  = instr_is32;
            snapAddr  = rom_addr;
            holdArmed = 1'b1;
         end
         if (pc_load) mpc = pc_target;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      reset = 1'b1; pc_load = 1'b0; pc_target = 8'h00; instr_ready = 1'b1;

      // Reset state and straight-line fetch.
      clearMem();
      mem[0] = 16'hE803; mem[1] = 16'hBB09; mem[2] = 16'hE009;
      doReset();
      checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rst_word0", {16'd0, instr_word0}, 32'd0);
      checkOutput("rst_word1", {16'd0, instr_word1}, 32'd0);
      checkOutput("rst_is32", {31'd0, instr_is32}, 32'd0);
      checkOutput("rst_pc", {24'd0, instr_pc}, 32'd0);
      checkOutput("rst_addr", {24'd0, rom_addr}, 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("s1_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("s1_pc", {24'd0, instr_pc}, 32'd0);
      checkOutput("s1_word0", {16'd0, instr_word0}, 32'h0000E803);
      checkOutput("s1_addr", {24'd0, rom_addr}, 32'd1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("s2_pc", {24'd0, instr_pc}, 32'd1);
      checkOutput("s2_word0", {16'd0, instr_word0}, 32'h0000BB09);
      checkOutput("s2_addr", {24'd0, rom_addr}, 32'd2);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("s3_pc", {24'd0, instr_pc}, 32'd2);
      checkOutput("s3_word0", {16'd0, instr_word0}, 32'h0000E009);
      checkOutput("s3_is32", {31'd0, instr_is32}, 32'd0);
      checkOutput("s3_addr", {24'd0, rom_addr}, 32'd3);

      // Two-word LDS.
      clearMem();
      mem[0] = 16'h9100; mem[1] = 16'h0060; mem[2] = 16'h0000;
      doReset();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("lds_gap_valid", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("lds_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("lds_word0", {16'd0, instr_word0}, 32'h00009100);
      checkOutput("lds_word1", {16'd0, instr_word1}, 32'h00000060);
      checkOutput("lds_is32", {31'd0, instr_is32}, 32'd1);
      checkOutput("lds_pc", {24'd0, instr_pc}, 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("lds_next_pc", {24'd0, instr_pc}, 32'd2);
      checkOutput("lds_next_is32", {31'd0, instr_is32}, 32'd0);

      // Backpressure: three stalled cycles, then resume without loss.
      clearMem();
      mem[0] = 16'hE803; mem[1] = 16'hBB09; mem[2] = 16'hE009;
      doReset();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
         checkOutput("bp_pc", {24'd0, instr_pc}, 32'd0);
         checkOutput("bp_valid", {31'd0, instr_valid}, 32'd1);
         checkOutput("bp_addr", {24'd0, rom_addr}, 32'd1);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("bp_resume_pc", {24'd0, instr_pc}, 32'd1);
      checkOutput("bp_resume_word0", {16'd0, instr_word0}, 32'h0000BB09);

      // Redirect while the second word of a JMP is pending.
      clearMem();
      mem[0] = 16'h940C; mem[1] = 16'h0010; mem[8'h20] = 16'hE123; mem[8'h21] = 16'hE456;
      doReset();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("rd_w1_valid", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 8'h20, 1'b1);
      checkOutput("rd_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("rd_addr", {24'd0, rom_addr}, 32'h20);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("rd_tgt_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("rd_tgt_pc", {24'd0, instr_pc}, 32'h20);
      checkOutput("rd_tgt_word0", {16'd0, instr_word0}, 32'h0000E123);

      // PC wrap: JMP at FF takes its operand from address 0.
      clearMem();
      mem[8'hFF] = 16'h940C; mem[0] = 16'h0004; mem[1] = 16'hE111;
      doReset();
      applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("wrap_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("wrap_word0", {16'd0, instr_word0}, 32'h0000940C);
      checkOutput("wrap_word1", {16'd0, instr_word1}, 32'h00000004);
      checkOutput("wrap_is32", {31'd0, instr_is32}, 32'd1);
      checkOutput("wrap_pc", {24'd0, instr_pc}, 32'hFF);
      checkOutput("wrap_addr", {24'd0, rom_addr}, 32'd1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("wrap_next_pc", {24'd0, instr_pc}, 32'd1);

      // Back-to-back redirects: the last target wins.
      clearMem();
      mem[8'h40] = 16'hE040; mem[8'h50] = 16'hE050;
      doReset();
      applyStimulus(1'b0, 1'b1, 8'h40, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'h50, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("dbl_pc", {24'd0, instr_pc}, 32'h50);
      checkOutput("dbl_word0", {16'd0, instr_word0}, 32'h0000E050);

      // Mixed program under an irregular ready pattern, checked by the stream model.
      for (int i = 0; i < 256; i++) begin
         if (i % 5 == 2)      mem[i] = 16'h940E;
         else if (i % 7 == 3) mem[i] = 16'h9200;
         else                 mem[i] = 16'hE000 + 16'(i);
      end
      doReset();
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'b0, (i == 30), 8'h10, (i % 3 != 0));
      end

`ifdef IFETCH_BREAK_HALT_EN
      // BREAK halts fetch until a redirect.
      clearMem();
      mem[0] = 16'h9598; mem[1] = 16'hE000;
      doReset();
      checkOutput("halt_rst", {31'd0, halted}, 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("brk_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("brk_word0", {16'd0, instr_word0}, 32'h00009598);
      checkOutput("brk_pc", {24'd0, instr_pc}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
         checkOutput("halt_valid", {31'd0, instr_valid}, 32'd0);
         checkOutput("halt_flag", {31'd0, halted}, 32'd1);
         checkOutput("halt_addr", {24'd0, rom_addr}, 32'd1);
      end
      applyStimulus(1'b0, 1'b1, 8'h01, 1'b1);
      checkOutput("unhalt_flag", {31'd0, halted}, 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("unhalt_word0", {16'd0, instr_word0}, 32'h0000E000);
      checkOutput("unhalt_pc", {24'd0, instr_pc}, 32'd1);
`endif

      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
